// File: rtl/ceq_seq_ctrl.sv
// Sequential case-equality engine: extends two operands to a common width and compares them CHUNK bits per cycle, LSB first.
// Define CEQ_SEQ_CTRL_EARLY_EXIT_EN to stop comparing at the first mismatching chunk.
module ceq_seq_ctrl #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [WIDTH-1:0]                req_a,
    input  logic [WIDTH-1:0]                req_b,
    input  logic [$clog2(WIDTH):0]          a_len,
    input  logic [$clog2(WIDTH):0]          b_len,
    input  logic                            sgn,
    output logic                            resp_valid,
    input  logic                            resp_ready,
    output logic                            resp_eq,
    output logic [$clog2(WIDTH)-1:0]        resp_idx,
    output logic [$clog2(WIDTH/CHUNK):0]    resp_chunks
);

    localparam int LW   = $clog2(WIDTH) + 1;
    localparam int IW   = $clog2(WIDTH);
    localparam int CW   = $clog2(WIDTH / CHUNK) + 1;
    localparam int LSBW = (CHUNK > 1) ? $clog2(CHUNK) : 1;

`ifdef CEQ_SEQ_CTRL_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        CMP,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_diff;
    logic [LW-1:0]    r_alen;
    logic [LW-1:0]    r_blen;
    logic             r_sgn;
    logic             r_mis;
    logic             r_fin;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    r_k;
    logic [IW-1:0]    r_idx;

    logic [LW-1:0]    w_alen_s;
    logic [LW-1:0]    w_blen_s;
    logic [LW-1:0]    w_n;
    logic [LW:0]      w_nround;
    logic [CW-1:0]    w_k;
    logic             w_a_msb;
    logic             w_b_msb;
    logic [WIDTH-1:0] w_ea;
    logic [WIDTH-1:0] w_eb;
    logic [WIDTH-1:0] w_mask;
    logic [CHUNK-1:0] w_cd;
    logic             w_hit;
    logic [LSBW-1:0]  w_lsb;
    logic [IW-1:0]    w_idx;
    logic [CW-1:0]    w_cnt_nx;

    assign w_alen_s = (a_len == '0 || a_len > LW'(WIDTH)) ? LW'(WIDTH) : a_len;
    assign w_blen_s = (b_len == '0 || b_len > LW'(WIDTH)) ? LW'(WIDTH) : b_len;
    assign w_n      = (r_alen > r_blen) ? r_alen : r_blen;
    assign w_nround = {1'b0, w_n} + (LW + 1)'(CHUNK - 1);
    assign w_k      = CW'(w_nround >> $clog2(CHUNK));

    // Extend both latched operands to the full width; bits at or above N are masked out later.
    always_comb begin
        w_a_msb = r_sgn & r_a[IW'(r_alen - LW'(1))];
        w_b_msb = r_sgn & r_b[IW'(r_blen - LW'(1))];
        w_ea    = '0;
        w_eb    = '0;
        w_mask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_ea[i]   = (i < int'(r_alen)) ? r_a[i] : w_a_msb;
            w_eb[i]   = (i < int'(r_blen)) ? r_b[i] : w_b_msb;
            w_mask[i] = (i < int'(w_n));
        end
    end

    // r_diff is shifted down one chunk per compare, so the current chunk always sits in the low bits.
    assign w_cd     = r_diff[CHUNK-1:0];
    assign w_hit    = |w_cd;
    assign w_cnt_nx = r_cnt + CW'(1);

    always_comb begin
        w_lsb = '0;
        for (int i = CHUNK - 1; i >= 0; i--) begin
            if (w_cd[i]) begin
                w_lsb = LSBW'(i);
            end
        end
    end

    assign w_idx = IW'(r_cnt) * IW'(CHUNK) + IW'(w_lsb);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            req_ready   <= 1'b1;
            resp_valid  <= 1'b0;
            resp_eq     <= 1'b0;
            resp_idx    <= '0;
            resp_chunks <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_alen      <= '0;
            r_blen      <= '0;
            r_sgn       <= 1'b0;
            r_mis       <= 1'b0;
            r_fin       <= 1'b0;
            r_cnt       <= '0;
            r_k         <= '0;
            r_idx       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_a       <= req_a;
                        r_b       <= req_b;
                        r_alen    <= w_alen_s;
                        r_blen    <= w_blen_s;
                        r_sgn     <= sgn;
                        req_ready <= 1'b0;
                        r_state   <= LOAD;
                    end
                end
                LOAD: begin
                    r_diff  <= (w_ea ^ w_eb) & w_mask;
                    r_k     <= w_k;
                    r_cnt   <= '0;
                    r_mis   <= 1'b0;
                    r_fin   <= 1'b0;
                    r_idx   <= '0;
                    r_state <= CMP;
                end
                CMP: begin
                    // The cycle after the final compare publishes the result.
                    if (r_fin) begin
                        resp_valid  <= 1'b1;
                        resp_eq     <= ~r_mis;
                        resp_idx    <= r_idx;
                        resp_chunks <= r_cnt;
                        r_state     <= DONE;
                    end else begin
                        r_diff <= r_diff >> CHUNK;
                        r_cnt  <= w_cnt_nx;
                        if (w_hit && !r_mis) begin
                            r_mis <= 1'b1;
                            r_idx <= w_idx;
                        end
                        if (w_cnt_nx == r_k || (EARLY_EXIT && w_hit)) begin
                            r_fin <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                        r_state    <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ceq_seq_ctrl.sv
// Directed self-checking bench for ceq_seq_ctrl; expectations follow CEQ_SEQ_CTRL_EARLY_EXIT_EN when defined.
module tb_ceq_seq_ctrl;

    localparam int WIDTH = 128;

`ifdef CEQ_SEQ_CTRL_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [7:0]       al;
        logic [WIDTH-1:0] b;
        logic [7:0]       bl;
        logic             s;
        logic             eq;
        logic [6:0]       idx;
        logic [3:0]       ch;
        int               lat;
    } vec_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [WIDTH-1:0] req_a = '0;
    logic [WIDTH-1:0] req_b = '0;
    logic [7:0]       a_len = '0;
    logic [7:0]       b_len = '0;
    logic             sgn = 1'b0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic             resp_eq;
    logic [6:0]       resp_idx;
    logic [3:0]       resp_chunks;

    int checks = 0;
    int errors = 0;

    ceq_seq_ctrl #(.WIDTH(128), .CHUNK(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .a_len(a_len), .b_len(b_len), .sgn(sgn),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_eq(resp_eq), .resp_idx(resp_idx), .resp_chunks(resp_chunks)
    );

    always #5 clk = ~clk;

    // Presents one request, lets it be accepted at the next edge and counts edges until resp_valid.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [7:0] al,
                                 input logic [WIDTH-1:0] b, input logic [7:0] bl,
                                 input logic s, output int lat);
        req_a = a; a_len = al; req_b = b; b_len = bl; sgn = s;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (resp_valid !== 1'b1 && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic completeResp();
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({req_ready, resp_valid, resp_eq, resp_idx, resp_chunks} !== {1'b1, 1'b0, 1'b0, 7'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL reset_values: got rdy=%0b vld=%0b eq=%0b idx=%0d ch=%0d, expected rdy=1 vld=0 eq=0 idx=0 ch=0",
                     req_ready, resp_valid, resp_eq, resp_idx, resp_chunks);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Table of width/sign/length combinations; expected values worked out by hand.
    task automatic test_extension();
        vec_t v[11];
        int   lat;
        v[0]  = '{128'h1FF, 8'd9, 128'h1FF, 8'd9, 1'b0, 1'b1, 7'd0, 4'd1, 3};
        v[1]  = '{128'hF, 8'd4, 128'h3F, 8'd6, 1'b1, 1'b1, 7'd0, 4'd1, 3};
        v[2]  = '{128'hF, 8'd4, 128'h3F, 8'd6, 1'b0, 1'b0, 7'd4, 4'd1, 3};
        v[3]  = '{128'hDEAD_0008_0000, 8'd20, 128'hFF_FFF8_0000, 8'd40, 1'b1, 1'b1, 7'd0, 4'd3, 5};
        v[4]  = '{128'hDEAD_0008_0000, 8'd20, 128'hFF_FFF8_0000, 8'd40, 1'b0, 1'b0, 7'd20,
                  EARLY ? 4'd2 : 4'd3, EARLY ? 4 : 5};
        v[5]  = '{128'h12345, 8'd20, 128'hF001_2345, 8'd20, 1'b0, 1'b1, 7'd0, 4'd2, 4};
        v[6]  = '{128'h0, 8'd64, 128'h0004_0000_0020_0000, 8'd64, 1'b0, 1'b0, 7'd21,
                  EARLY ? 4'd2 : 4'd4, EARLY ? 4 : 6};
        v[7]  = '{128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, 8'd128,
                  128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210 ^ (128'h1 << 100), 8'd128, 1'b0,
                  1'b0, 7'd100, EARLY ? 4'd7 : 4'd8, EARLY ? 9 : 10};
        v[8]  = '{{128{1'b1}}, 8'd0, {128{1'b1}}, 8'd200, 1'b0, 1'b1, 7'd0, 4'd8, 10};
        v[9]  = '{128'h0, 8'd0, 128'h1, 8'd1, 1'b0, 1'b0, 7'd0, EARLY ? 4'd1 : 4'd8, EARLY ? 3 : 10};
        v[10] = '{128'h80, 8'd8, {{121{1'b1}}, 7'd0}, 8'd128, 1'b1, 1'b1, 7'd0, 4'd8, 10};
        for (int i = 0; i < 11; i++) begin
            applyStimulus(v[i].a, v[i].al, v[i].b, v[i].bl, v[i].s, lat);
            checks++;
            if (lat !== v[i].lat) begin
                errors++;
                $display("[TB] FAIL vec%0d latency: got %0d cycles, expected %0d", i, lat, v[i].lat);
            end
            checks++;
            if ({resp_eq, resp_idx, resp_chunks} !== {v[i].eq, v[i].idx, v[i].ch}) begin
                errors++;
                $display("[TB] FAIL vec%0d result: got eq=%0b idx=%0d ch=%0d, expected eq=%0b idx=%0d ch=%0d",
                         i, resp_eq, resp_idx, resp_chunks, v[i].eq, v[i].idx, v[i].ch);
            end
            completeResp();
            checks++;
            if ({resp_valid, req_ready} !== 2'b01) begin
                errors++;
                $display("[TB] FAIL vec%0d handshake: got vld=%0b rdy=%0b, expected vld=0 rdy=1",
                         i, resp_valid, req_ready);
            end
        end
    endtask

    task automatic test_backpressure();
        int lat;
        applyStimulus(128'h5A, 8'd8, 128'h1A, 8'd8, 1'b0, lat);
        checks++;
        if (lat !== 3) begin
            errors++;
            $display("[TB] FAIL bp_latency: got %0d cycles, expected 3", lat);
        end
        // A request offered while busy must be ignored.
        req_a = 128'h3; req_b = 128'h3; a_len = 8'd2; b_len = 8'd2; req_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({resp_valid, req_ready, resp_eq, resp_idx, resp_chunks} !== {1'b1, 1'b0, 1'b0, 7'd6, 4'd1}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got vld=%0b rdy=%0b eq=%0b idx=%0d ch=%0d, expected vld=1 rdy=0 eq=0 idx=6 ch=1",
                         c, resp_valid, req_ready, resp_eq, resp_idx, resp_chunks);
            end
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        completeResp();
        checks++;
        if ({resp_valid, req_ready, resp_eq, resp_idx, resp_chunks} !== {1'b0, 1'b1, 1'b0, 7'd6, 4'd1}) begin
            errors++;
            $display("[TB] FAIL bp_after: got vld=%0b rdy=%0b eq=%0b idx=%0d ch=%0d, expected vld=0 rdy=1 eq=0 idx=6 ch=1",
                     resp_valid, req_ready, resp_eq, resp_idx, resp_chunks);
        end
        applyStimulus(128'h3, 8'd2, 128'h1, 8'd2, 1'b0, lat);
        checks++;
        if (lat !== 3 || {resp_eq, resp_idx, resp_chunks} !== {1'b0, 7'd1, 4'd1}) begin
            errors++;
            $display("[TB] FAIL bp_next: got lat=%0d eq=%0b idx=%0d ch=%0d, expected lat=3 eq=0 idx=1 ch=1",
                     lat, resp_eq, resp_idx, resp_chunks);
        end
        completeResp();
    endtask

    task automatic test_reset_mid();
        int lat;
        int stray;
        req_a = {128{1'b1}}; req_b = 128'h0; a_len = 8'd128; b_len = 8'd128; sgn = 1'b0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, resp_valid, resp_eq, resp_idx, resp_chunks} !== {1'b1, 1'b0, 1'b0, 7'd0, 4'd0}) begin
            errors++;
            $display("[TB] FAIL mid_reset: got rdy=%0b vld=%0b eq=%0b idx=%0d ch=%0d, expected rdy=1 vld=0 eq=0 idx=0 ch=0",
                     req_ready, resp_valid, resp_eq, resp_idx, resp_chunks);
        end
        #1;
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (resp_valid !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++;
            $display("[TB] FAIL dropped_request: got %0d cycles with resp_valid, expected 0", stray);
        end
        applyStimulus(128'h1, 8'd1, 128'h3, 8'd2, 1'b1, lat);
        checks++;
        if (lat !== 3 || {resp_eq, resp_idx, resp_chunks} !== {1'b1, 7'd0, 4'd1}) begin
            errors++;
            $display("[TB] FAIL post_reset: got lat=%0d eq=%0b idx=%0d ch=%0d, expected lat=3 eq=1 idx=0 ch=1",
                     lat, resp_eq, resp_idx, resp_chunks);
        end
        completeResp();
    endtask

    initial begin
        test_reset();
        test_extension();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
